// File: rtl/tdm_lane_receiver_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tdm_lane_receiver_if : TDM link handshake (data/valid/sof/ready)|
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface tdm_lane_receiver_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_sof;
  logic             in_ready;

  modport master (output in_data, output in_valid, output in_sof, input in_ready);
  modport slave  (input in_data, input in_valid, input in_sof, output in_ready);
endinterface
`default_nettype wire

// File: rtl/tdm_lane_receiver.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tdm_lane_receiver : reassembles 4-slot TDM frames, commits lanes |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tdm_lane_receiver #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  tdm_lane_receiver_if.slave    link,
  output logic [WIDTH-1:0]      lane0,
  output logic [WIDTH-1:0]      lane1,
  output logic [WIDTH-1:0]      lane2,
  output logic [WIDTH-1:0]      lane3,
  output logic [1:0]            slot,
  output logic                  frame_done,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECV   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] shadow0, shadow1, shadow2;
  logic [CNT_W-1:0] idle_cnt;

  logic accept;
  logic do_start, do_store, do_commit, do_restart, do_timeout;

  assign link.in_ready = (state != S_COMMIT);
  assign accept        = link.in_valid & link.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    do_start   = 1'b0;
    do_store   = 1'b0;
    do_commit  = 1'b0;
    do_restart = 1'b0;
    do_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && link.in_sof) begin
          do_start   = 1'b1;
          next_state = S_RECV;
        end
      end
      S_RECV: begin
        // A restart needs an accept, a timeout needs its absence, so they never collide
        if (accept) begin
          if (link.in_sof) begin
            do_start   = 1'b1;
            do_restart = 1'b1;
          end else if (slot == 2'd3) begin
            do_commit  = 1'b1;
            next_state = S_COMMIT;
          end else begin
            do_store   = 1'b1;
          end
        end else if (idle_cnt == CNT_W'(TIMEOUT - 1)) begin
          do_timeout = 1'b1;
          next_state = S_IDLE;
        end
      end
      S_COMMIT: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane0      <= '0;
      lane1      <= '0;
      lane2      <= '0;
      lane3      <= '0;
      shadow0    <= '0;
      shadow1    <= '0;
      shadow2    <= '0;
      slot       <= 2'd0;
      idle_cnt   <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= do_commit;
      frame_err  <= do_restart | do_timeout;

      if (state == S_RECV && !accept && !do_timeout) idle_cnt <= idle_cnt + 1'b1;
      else                                           idle_cnt <= '0;

      if (do_start) begin
        shadow0 <= link.in_data;
        slot    <= 2'd1;
      end else if (do_store) begin
        if (slot == 2'd1) shadow1 <= link.in_data;
        else              shadow2 <= link.in_data;
        slot <= slot + 2'd1;
      end else if (do_commit) begin
        lane0 <= shadow0;
        lane1 <= shadow1;
        lane2 <= shadow2;
        lane3 <= link.in_data;
        slot  <= 2'd0;
      end else if (do_timeout) begin
        slot  <= 2'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tdm_lane_receiver.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_tdm_lane_receiver : directed self-checking bench              |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_tdm_lane_receiver;
  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [WIDTH-1:0] lane0, lane1, lane2, lane3;
  logic [1:0] slot;
  logic frame_done, frame_err;

  int n_cmp = 0;
  int n_err = 0;

  tdm_lane_receiver_if #(.WIDTH(WIDTH)) link ();

  tdm_lane_receiver #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .link       (link),
    .lane0      (lane0),
    .lane1      (lane1),
    .lane2      (lane2),
    .lane3      (lane3),
    .slot       (slot),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_lanes(input string tag, input logic [15:0] exp);
    chk(tag, {16'h0, lane0, lane1, lane2, lane3}, {16'h0, exp});
  endtask

  task automatic chk_flags(input string tag, input logic rdy, input logic [1:0] s,
                           input logic done, input logic err);
    chk(tag, {27'h0, link.in_ready, slot, frame_done, frame_err},
             {27'h0, rdy, s, done, err});
  endtask

  task automatic drive(input logic v, input logic sof, input logic [WIDTH-1:0] d);
    link.in_valid = v;
    link.in_sof   = sof;
    link.in_data  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 4'h0);
    #12;
    chk_lanes("reset_lanes", 16'h0000);
    chk_flags("reset_flags", 1'b1, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk_lanes("idle_lanes", 16'h0000);
    chk_flags("idle_flags", 1'b1, 2'd0, 1'b0, 1'b0);

    // Back-to-back frame 3,5,9,C
    drive(1'b1, 1'b1, 4'h3); tick();
    chk_flags("f1_s0", 1'b1, 2'd1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'h5); tick();
    chk_flags("f1_s1", 1'b1, 2'd2, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'h9); tick();
    chk_flags("f1_s2", 1'b1, 2'd3, 1'b0, 1'b0);
    chk_lanes("f1_no_early_commit", 16'h0000);
    drive(1'b1, 1'b0, 4'hC); tick();
    drive(1'b0, 1'b0, 4'h0);
    chk_lanes("f1_lanes", 16'h359C);
    chk_flags("f1_commit", 1'b0, 2'd0, 1'b1, 1'b0);
    tick();
    chk_flags("f1_after", 1'b1, 2'd0, 1'b0, 1'b0);

    // Interrupted frame A,B then restart 1,2,3,4
    drive(1'b1, 1'b1, 4'hA); tick();
    drive(1'b1, 1'b0, 4'hB); tick();
    drive(1'b1, 1'b1, 4'h1); tick();
    chk_flags("f2_restart_err", 1'b1, 2'd1, 1'b0, 1'b1);
    chk_lanes("f2_lanes_held", 16'h359C);
    drive(1'b1, 1'b0, 4'h2); tick();
    chk_flags("f2_err_once", 1'b1, 2'd2, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'h3); tick();
    drive(1'b1, 1'b0, 4'h4); tick();
    drive(1'b0, 1'b0, 4'h0);
    chk_lanes("f2_lanes", 16'h1234);
    chk_flags("f2_commit", 1'b0, 2'd0, 1'b1, 1'b0);
    tick();

    // Stalled frame 7,7 then TIMEOUT idle cycles
    drive(1'b1, 1'b1, 4'h7); tick();
    drive(1'b1, 1'b0, 4'h7); tick();
    drive(1'b0, 1'b0, 4'h0);
    tick(); tick(); tick();
    chk_flags("f3_idle3", 1'b1, 2'd2, 1'b0, 1'b0);
    tick();
    chk_flags("f3_timeout", 1'b1, 2'd0, 1'b0, 1'b1);
    chk_lanes("f3_lanes_kept", 16'h1234);
    tick();
    chk_flags("f3_after", 1'b1, 2'd0, 1'b0, 1'b0);

    // Valid held through COMMIT with next sof word E
    drive(1'b1, 1'b1, 4'h8); tick();
    drive(1'b1, 1'b0, 4'h9); tick();
    drive(1'b1, 1'b0, 4'hA); tick();
    drive(1'b1, 1'b0, 4'hB); tick();
    drive(1'b1, 1'b1, 4'hE);
    chk_flags("f4_commit_stall", 1'b0, 2'd0, 1'b1, 1'b0);
    chk_lanes("f4_lanes", 16'h89AB);
    tick();
    chk_flags("f4_not_taken", 1'b1, 2'd0, 1'b0, 1'b0);
    tick();
    chk_flags("f4_e_taken", 1'b1, 2'd1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'h1); tick();
    drive(1'b1, 1'b0, 4'h2); tick();
    drive(1'b1, 1'b0, 4'h3); tick();
    drive(1'b0, 1'b0, 4'h0);
    chk_lanes("f5_lanes", 16'hE123);
    chk_flags("f5_commit", 1'b0, 2'd0, 1'b1, 1'b0);
    tick();

    // Non-sof words dropped in IDLE, then reset mid-frame
    drive(1'b1, 1'b0, 4'h1); tick();
    chk_flags("drop1", 1'b1, 2'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'h2); tick();
    chk_flags("drop2", 1'b1, 2'd0, 1'b0, 1'b0);
    chk_lanes("drop_lanes", 16'hE123);
    drive(1'b1, 1'b1, 4'hD); tick();
    drive(1'b1, 1'b0, 4'h6); tick();
    chk_flags("pre_reset", 1'b1, 2'd2, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_lanes("mid_reset_lanes", 16'h0000);
    chk_flags("mid_reset_flags", 1'b1, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Shadow registers must have been cleared: frame with slots 1,2 fresh
    drive(1'b1, 1'b1, 4'h5); tick();
    drive(1'b1, 1'b0, 4'h0); tick();
    drive(1'b1, 1'b0, 4'h0); tick();
    drive(1'b1, 1'b0, 4'hF); tick();
    drive(1'b0, 1'b0, 4'h0);
    chk_lanes("post_reset_lanes", 16'h500F);
    chk_flags("post_reset_commit", 1'b0, 2'd0, 1'b1, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
